date_decode: RTL and testbench
==============================

DATE_DECODE -- requirements
Module: date_decode

Interface
REQ-001 SHALL have parameter LEAP_EN, default 1, meaning 1 honours the leap input and 0 forces a 365-day year.
REQ-002 SHALL have parameter ZERO_BASED, default 0, meaning 0 maps day-of-year 1 to Jan 1 and 1 maps day-of-year 0 to Jan 1.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request conversion of the current digit and leap inputs.
REQ-006 SHALL have ports hundreds, tens and ones, each input, 4 bits: BCD day-of-year digits.
REQ-007 SHALL have port leap, input, 1 bit: 1 marks a 29-day February.
REQ-008 SHALL have ports month_tens and month_ones, each output, 4 bits: BCD month, 01-12.
REQ-009 SHALL have ports day_tens and day_ones, each output, 4 bits: BCD day of month, 01-31.
REQ-010 SHALL have port busy, output, 1 bit: conversion in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-012 SHALL have port err, output, 1 bit: the last request was invalid; held until the next accepted start.

Function
REQ-013 SHALL use three states, IDLE, CONV and SEARCH; all outputs SHALL be registered.
REQ-014 In IDLE, start=1 at an edge SHALL latch hundreds, tens, ones and leap (leap is latched as 0 when LEAP_EN=0), clear err, and enter CONV.
REQ-015 In CONV, one edge SHALL form a 9-bit binary value V = 100*hundreds + 10*tens + ones, plus 1 when ZERO_BASED=1, then range-check it.
REQ-016 A request SHALL be invalid if any digit exceeds 9, if V=0, or if V > 365+leap.
REQ-017 For an invalid request, the CONV edge SHALL set err=1, set all month and day digits to 0, pulse done, and return to IDLE.
REQ-018 For a valid request, the CONV edge SHALL set remainder R=V and month index m=1, then enter SEARCH.
REQ-019 In SEARCH, the month lengths SHALL be 31, 28+leap, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31.
REQ-020 In SEARCH, each edge SHALL examine exactly one month.
REQ-021 At a SEARCH edge, if R <= len(m), month SHALL be set to m and day to R (both converted to BCD), done SHALL pulse, and the state SHALL return to IDLE.
REQ-022 At a SEARCH edge, if R > len(m), R SHALL become R - len(m) and m SHALL become m+1.
REQ-023 Latency SHALL be M+2 edges from the start-sampling edge to the edge raising done, where M is the result month; an invalid request SHALL take 2 edges.
REQ-024 busy SHALL be 1 in CONV and SEARCH and 0 in IDLE.
REQ-025 done SHALL be high for exactly one cycle per accepted start.
REQ-026 start SHALL be ignored while busy=1; it is neither queued nor does it alter latched inputs.
REQ-027 start=1 in the cycle done=1 (state IDLE) SHALL be accepted.
REQ-028 Changes to the digit or leap inputs after the start-sampling edge SHALL not affect the result in progress.
REQ-029 month, day and err SHALL hold their last values between conversions.

Reset
REQ-030 reset_n=0 SHALL immediately force state IDLE, all month and day digits to 0, and busy, done and err to 0, regardless of clock.
REQ-031 A reset asserted during CONV or SEARCH SHALL abort the conversion without a done pulse.
REQ-032 After reset release, the first start SHALL behave as from power-up.

Verification
REQ-033 Bench SHALL drive digits 0,0,1, leap=0, start at edge k and check done at edge k+3 with month 0,1 and day 0,1.
REQ-034 Bench SHALL drive digits 0,6,0: leap=1 gives month 0,2 and day 2,9; leap=0 gives month 0,3 and day 0,1 at edge k+5.
REQ-035 Bench SHALL drive digits 3,6,6: leap=0 gives err=1 and month and day 0 at edge k+2; leap=1 gives month 1,2 and day 3,1 at edge k+14.
REQ-036 Bench SHALL drive digit ones=4'hA and check err=1 and a done pulse at k+2; then drive 0,0,0 with ZERO_BASED=0 and check err=1.
REQ-037 Bench SHALL pulse start mid-SEARCH with changed digits and check one done only, with the original result.
REQ-038 Bench SHALL assert reset_n=0 mid-SEARCH and check all outputs 0 at once, no done pulse, and a correct next conversion.

Source files
------------

// File: rtl/date_decode.sv
// Day-of-year to calendar date converter.
// Takes a three-digit BCD day-of-year and a leap flag and produces a BCD
// month and day of month. It walks through the months one per clock,
// subtracting each month length in turn, so the latency depends on the
// result month.
module date_decode #(
    parameter int LEAP_EN    = 1,
    parameter int ZERO_BASED = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       leap,
    output logic [3:0] month_tens,
    output logic [3:0] month_ones,
    output logic [3:0] day_tens,
    output logic [3:0] day_ones,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        SEARCH = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] hun_q;
    logic [3:0] ten_q;
    logic [3:0] one_q;
    logic       leap_q;
    logic [8:0] rem;
    logic [3:0] mon;

    // Number of days in month m (1..12).
    function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
        logic [4:0] len;
        case (m)
            4'd2:                      len = lp ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   len = 5'd30;
            default:                   len = 5'd31;
        endcase
        return len;
    endfunction

    // Binary 0..31 to two BCD digits {tens, ones}.
    function automatic logic [7:0] to_bcd(input logic [4:0] v);
        logic [3:0] t;
        logic [4:0] r;
        if (v >= 5'd30) begin
            t = 4'd3;
            r = v - 5'd30;
        end else if (v >= 5'd20) begin
            t = 4'd2;
            r = v - 5'd20;
        end else if (v >= 5'd10) begin
            t = 4'd1;
            r = v - 5'd10;
        end else begin
            t = 4'd0;
            r = v;
        end
        return {t, r[3:0]};
    endfunction

    // 11 bits so that out-of-range digits (up to 15) cannot wrap into a
    // seemingly valid value before the digit check rejects them.
    logic [10:0] v_full;
    logic [10:0] v_limit;
    logic        digit_bad;
    logic        v_ok;
    logic [4:0]  cur_len;
    logic        fits;
    logic [7:0]  mon_bcd;
    logic [7:0]  day_bcd;

    assign v_full    = 11'(hun_q) * 11'd100 + 11'(ten_q) * 11'd10 + 11'(one_q)
                     + ((ZERO_BASED != 0) ? 11'd1 : 11'd0);
    assign v_limit   = 11'd365 + 11'(leap_q);
    assign digit_bad = (hun_q > 4'd9) || (ten_q > 4'd9) || (one_q > 4'd9);
    assign v_ok      = !digit_bad && (v_full != 11'd0) && (v_full <= v_limit);
    assign cur_len   = month_len(mon, leap_q);
    assign fits      = (rem <= {4'd0, cur_len});
    assign mon_bcd   = to_bcd({1'b0, mon});
    assign day_bcd   = to_bcd(rem[4:0]);

    // Control FSM with registered outputs; latches inputs on an accepted start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            hun_q      <= 4'd0;
            ten_q      <= 4'd0;
            one_q      <= 4'd0;
            leap_q     <= 1'b0;
            rem        <= 9'd0;
            mon        <= 4'd0;
            month_tens <= 4'd0;
            month_ones <= 4'd0;
            day_tens   <= 4'd0;
            day_ones   <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        hun_q  <= hundreds;
                        ten_q  <= tens;
                        one_q  <= ones;
                        leap_q <= (LEAP_EN != 0) ? leap : 1'b0;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    if (!v_ok) begin
                        err        <= 1'b1;
                        month_tens <= 4'd0;
                        month_ones <= 4'd0;
                        day_tens   <= 4'd0;
                        day_ones   <= 4'd0;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        rem   <= v_full[8:0];
                        mon   <= 4'd1;
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    // December always fits: the range check bounds the remainder.
                    if (fits) begin
                        month_tens <= mon_bcd[7:4];
                        month_ones <= mon_bcd[3:0];
                        day_tens   <= day_bcd[7:4];
                        day_ones   <= day_bcd[3:0];
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        rem <= rem - {4'd0, cur_len};
                        mon <= mon + 4'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_date_decode.sv
// Directed bench for date_decode: table of day-of-year vectors with
// hand-computed dates and latencies, plus hand-written corner sequences.
module tb_date_decode;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       leap;
    logic [3:0] month_tens;
    logic [3:0] month_ones;
    logic [3:0] day_tens;
    logic [3:0] day_ones;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    date_decode #(.LEAP_EN(1), .ZERO_BASED(0)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .hundreds   (hundreds),
        .tens       (tens),
        .ones       (ones),
        .leap       (leap),
        .month_tens (month_tens),
        .month_ones (month_ones),
        .day_tens   (day_tens),
        .day_ones   (day_ones),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic       lp;
        logic       e;
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] dt;
        logic [3:0] dd;
        int         lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] result_word();
        return {15'd0, err, month_tens, month_ones, day_tens, day_ones};
    endfunction

    // Drive a request at a negedge (after edge k) and check done at edge k+lat.
    task automatic run_vec(input string name, input vec_t v);
        int early;
        int nobusy;
        early  = 0;
        nobusy = 0;
        hundreds = v.h;
        tens     = v.t;
        ones     = v.o;
        leap     = v.lp;
        start    = 1'b1;
        for (int n = 1; n <= v.lat; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (n == 1) begin
                start    = 1'b0;
                hundreds = 4'(~v.h);
                tens     = 4'(~v.t);
                ones     = 4'(~v.o);
                leap     = ~v.lp;
            end
            if (n < v.lat) begin
                if (done) early++;
                if (!busy) nobusy++;
            end
        end
        check({name, "_early_done"}, 32'(early), 32'd0);
        check({name, "_busy"}, 32'(nobusy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_busy_end"}, 32'(busy), 32'd0);
        check({name, "_result"}, result_word(),
              {15'd0, v.e, v.mt, v.mo, v.dt, v.dd});
    endtask

    initial begin
        int cnt;
        vec_t v;

        //          h     t     o     lp    e     mt    mo    dt    dd   lat
        vecs[0]  = '{4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 4'd1, 3};
        vecs[1]  = '{4'd0, 4'd6, 4'd0, 1'b1, 1'b0, 4'd0, 4'd2, 4'd2, 4'd9, 4};
        vecs[2]  = '{4'd0, 4'd6, 4'd0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd0, 4'd1, 5};
        vecs[3]  = '{4'd3, 4'd6, 4'd6, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 2};
        vecs[4]  = '{4'd3, 4'd6, 4'd6, 1'b1, 1'b0, 4'd1, 4'd2, 4'd3, 4'd1, 14};
        vecs[5]  = '{4'd0, 4'd0, 4'hA, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 2};
        vecs[6]  = '{4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 2};
        vecs[7]  = '{4'd3, 4'd6, 4'd5, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 4'd1, 14};
        vecs[8]  = '{4'd0, 4'd3, 4'd2, 1'b0, 1'b0, 4'd0, 4'd2, 4'd0, 4'd1, 4};
        vecs[9]  = '{4'd0, 4'd3, 4'd1, 1'b1, 1'b0, 4'd0, 4'd1, 4'd3, 4'd1, 3};
        vecs[10] = '{4'd9, 4'd9, 4'd9, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 2};
        vecs[11] = '{4'hA, 4'd0, 4'd0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 2};
        vecs[12] = '{4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd7, 4'd1, 4'd9, 9};
        vecs[13] = '{4'd1, 4'd5, 4'd2, 1'b1, 1'b0, 4'd0, 4'd5, 4'd3, 4'd1, 7};

        reset_n  = 1'b0;
        start    = 1'b0;
        hundreds = 4'd0;
        tens     = 4'd0;
        ones     = 4'd0;
        leap     = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("reset_state", {15'd0, err, month_tens, month_ones, day_tens, day_ones},
              32'd0);
        check("reset_busy_done", {30'd0, busy, done}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Back-to-back table: each start lands in the cycle done is high.
        for (int i = 0; i < 14; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // err and zeroed outputs hold while idle.
        start = 1'b0;
        run_vec("hold_setup", vecs[5]);
        cnt = 0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) cnt++;
        end
        check("hold_no_done", 32'(cnt), 32'd0);
        check("hold_err", result_word(), 32'h10000);

        // start pulsed mid-SEARCH with different inputs must be ignored.
        hundreds = 4'd3;
        tens     = 4'd6;
        ones     = 4'd5;
        leap     = 1'b0;
        start    = 1'b1;
        cnt      = 0;
        for (int n = 1; n <= 14; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (n == 1) start = 1'b0;
            if (n == 5) begin
                start    = 1'b1;
                hundreds = 4'd0;
                tens     = 4'd0;
                ones     = 4'd1;
                leap     = 1'b1;
            end
            if (n == 6) start = 1'b0;
            if (n < 14 && done) cnt++;
        end
        check("midstart_early_done", 32'(cnt), 32'd0);
        check("midstart_done", 32'(done), 32'd1);
        check("midstart_result", result_word(), 32'h01231);
        cnt = 0;
        for (int n = 0; n < 16; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) cnt++;
        end
        check("midstart_extra_done", 32'(cnt), 32'd0);

        // Reset mid-SEARCH aborts immediately with no done.
        hundreds = 4'd2;
        tens     = 4'd0;
        ones     = 4'd0;
        leap     = 1'b0;
        start    = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (n == 1) start = 1'b0;
        end
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {13'd0, busy, done, err, month_tens, month_ones, day_tens, day_ones},
              32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        cnt = 0;
        for (int n = 0; n < 16; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (done || busy) cnt++;
        end
        check("post_reset_quiet", 32'(cnt), 32'd0);
        v = vecs[12];
        run_vec("post_reset", v);

        start = 1'b0;
        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
